// File: rtl/gpio_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : gpio_sync_gen
//  Purpose  : Transmit side of the GPIO sync link. Produces a square sync
//             signal with a programmable period and high time, as a finite
//             burst or continuously, plus a one-cycle TRIG on every rising
//             edge of the sync signal for local chirp start.
//  Ports    : CLK        system clock (rising edge)
//             RSET       asynchronous active-low reset
//             EN         level enable, deassertion aborts a run
//             START      start request, honoured only while idle
//             STOP       graceful stop, the current period completes
//             PERIOD     sync period in CLK cycles (clamped to >= 2)
//             HIGH_T     high time in CLK cycles (clamped to 1..per-1)
//             NBURST     number of periods, 0 = continuous
//             SIG_OUT    square sync signal to the GPIO pad
//             TRIG       one-cycle pulse with every SIG_OUT rising edge
//             BUSY       high whenever the generator is not idle
//             DONE       one-cycle pulse on burst completion or stop
//             PULSE_CNT  completed periods since the last start
//  Revision : 1.0  initial release
// ============================================================================
module gpio_sync_gen #(
    parameter int CNT_W   = 16,
    parameter int BURST_W = 8
) (
    input  logic               CLK,
    input  logic               RSET,
    input  logic               EN,
    input  logic               START,
    input  logic               STOP,
    input  logic [CNT_W-1:0]   PERIOD,
    input  logic [CNT_W-1:0]   HIGH_T,
    input  logic [BURST_W-1:0] NBURST,
    output logic               SIG_OUT,
    output logic               TRIG,
    output logic               BUSY,
    output logic               DONE,
    output logic [BURST_W-1:0] PULSE_CNT
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_LOW  = 2'd3;

    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_TWO = CNT_W'(2);

    logic [1:0]         r_state;
    logic               r_start;   // START captured while idle
    logic               r_stop;    // sticky graceful-stop request
    logic [CNT_W-1:0]   r_hi;      // latched high time
    logic [CNT_W-1:0]   r_lo;      // latched low time (per - hi)
    logic [BURST_W-1:0] r_nb;      // latched burst length
    logic [CNT_W-1:0]   r_cnt;     // phase counter, counts down to 1
    logic [BURST_W-1:0] r_pcnt;
    logic               r_sig;
    logic               r_trig;
    logic               r_busy;
    logic               r_done;

    logic [CNT_W-1:0]   w_per_clamp;
    logic [CNT_W-1:0]   w_hi_nz;
    logic [CNT_W-1:0]   w_hi_clamp;
    logic [1:0]         w_next;
    logic [CNT_W-1:0]   w_cnt;
    logic [BURST_W-1:0] w_pcnt;
    logic               w_stop;
    logic               w_load;
    logic               w_trig;
    logic               w_done;

    // Clamp the programmed shape so both phases last at least one cycle.
    assign w_per_clamp = (PERIOD < c_TWO) ? c_TWO : PERIOD;
    assign w_hi_nz     = (HIGH_T == '0) ? c_ONE : HIGH_T;
    assign w_hi_clamp  = (w_hi_nz >= w_per_clamp) ? (w_per_clamp - c_ONE) : w_hi_nz;

    always_comb begin
        w_next = r_state;
        w_cnt  = r_cnt;
        w_pcnt = r_pcnt;
        w_stop = r_stop;
        w_load = 1'b0;
        w_trig = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_start) begin
                    w_next = S_LOAD;
                    w_pcnt = '0;
                end
            end
            S_LOAD: begin
                if (!EN) begin
                    w_next = S_IDLE;
                end else begin
                    w_load = 1'b1;
                    w_next = S_HIGH;
                    w_cnt  = w_hi_clamp;
                    w_stop = STOP;
                    w_trig = 1'b1;
                end
            end
            S_HIGH: begin
                if (!EN) begin
                    w_next = S_IDLE;
                end else begin
                    w_stop = r_stop | STOP;
                    if (r_cnt == c_ONE) begin
                        w_next = S_LOW;
                        w_cnt  = r_lo;
                    end else begin
                        w_cnt = r_cnt - c_ONE;
                    end
                end
            end
            S_LOW: begin
                if (!EN) begin
                    w_next = S_IDLE;
                end else begin
                    w_stop = r_stop | STOP;
                    if (r_cnt == c_ONE) begin
                        // Period complete: count it, then finish or rise again.
                        w_pcnt = r_pcnt + BURST_W'(1);
                        if (((r_nb != '0) && (w_pcnt == r_nb)) || w_stop) begin
                            w_next = S_IDLE;
                            w_done = 1'b1;
                        end else begin
                            w_next = S_HIGH;
                            w_cnt  = r_hi;
                            w_trig = 1'b1;
                        end
                    end else begin
                        w_cnt = r_cnt - c_ONE;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSET) begin
        if (!RSET) begin
            r_state <= S_IDLE;
            r_start <= 1'b0;
            r_stop  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_nb    <= '0;
            r_cnt   <= '0;
            r_pcnt  <= '0;
            r_sig   <= 1'b0;
            r_trig  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            // START only counts while idle; a request seen during a run is dropped.
            r_start <= START & EN & (r_state == S_IDLE);
            r_stop  <= w_stop;
            r_cnt   <= w_cnt;
            r_pcnt  <= w_pcnt;
            if (w_load) begin
                r_hi <= w_hi_clamp;
                r_lo <= w_per_clamp - w_hi_clamp;
                r_nb <= NBURST;
            end
            // Outputs are registered from the next state so they track it exactly.
            r_sig  <= (w_next == S_HIGH);
            r_trig <= w_trig;
            r_busy <= (w_next != S_IDLE);
            r_done <= w_done;
        end
    end

    assign SIG_OUT   = r_sig;
    assign TRIG      = r_trig;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign PULSE_CNT = r_pcnt;

endmodule
`default_nettype wire

// File: tb/tb_gpio_sync_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gpio_sync_gen
//  Purpose  : Self-checking bench for gpio_sync_gen: a vector table, directed
//             multi-cycle sequences and randomized stimulus, all compared
//             cycle by cycle against a period-position reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gpio_sync_gen;

    logic        CLK;
    logic        RSET;
    logic        EN;
    logic        START;
    logic        STOP;
    logic [15:0] PERIOD;
    logic [15:0] HIGH_T;
    logic [7:0]  NBURST;
    logic        SIG_OUT;
    logic        TRIG;
    logic        BUSY;
    logic        DONE;
    logic [7:0]  PULSE_CNT;

    int n_vec = 0;
    int n_err = 0;

    gpio_sync_gen #(.CNT_W(16), .BURST_W(8)) dut (
        .CLK      (CLK),
        .RSET     (RSET),
        .EN       (EN),
        .START    (START),
        .STOP     (STOP),
        .PERIOD   (PERIOD),
        .HIGH_T   (HIGH_T),
        .NBURST   (NBURST),
        .SIG_OUT  (SIG_OUT),
        .TRIG     (TRIG),
        .BUSY     (BUSY),
        .DONE     (DONE),
        .PULSE_CNT(PULSE_CNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // ---------------- reference model ----------------
    // Mode: 0 idle, 1 start seen, 2 loading, 3 running.
    // While running, m_t is the cycle position inside the current period.
    int          m_mode;
    int unsigned m_t, m_per, m_hi;
    logic [7:0]  m_nb, m_pc;
    bit          m_stop;
    bit          e_sig, e_trig, e_busy, e_done;

    task automatic model_reset();
        m_mode = 0; m_t = 0; m_per = 0; m_hi = 0; m_nb = 0; m_pc = 0;
        m_stop = 0; e_sig = 0; e_trig = 0; e_busy = 0; e_done = 0;
    endtask

    task automatic model_step();
        e_trig = 0;
        e_done = 0;
        case (m_mode)
            0: begin
                e_sig = 0; e_busy = 0;
                if (START && EN) m_mode = 1;
            end
            1: begin
                m_mode = 2; m_pc = 0; e_busy = 1; e_sig = 0;
            end
            2: begin
                if (!EN) begin
                    m_mode = 0; e_busy = 0; e_sig = 0;
                end else begin
                    m_per = (PERIOD < 2) ? 2 : int'(PERIOD);
                    m_hi  = (HIGH_T == 0) ? 1 : int'(HIGH_T);
                    if (m_hi >= m_per) m_hi = m_per - 1;
                    m_nb = NBURST; m_stop = STOP; m_t = 0; m_mode = 3;
                    e_sig = 1; e_trig = 1; e_busy = 1;
                end
            end
            default: begin
                if (!EN) begin
                    m_mode = 0; e_sig = 0; e_busy = 0;
                end else begin
                    m_stop = m_stop | STOP;
                    e_busy = 1;
                    if (m_t == m_per - 1) begin
                        m_pc = m_pc + 8'd1;
                        if ((m_nb != 0 && m_pc == m_nb) || m_stop) begin
                            m_mode = 0; e_done = 1; e_sig = 0; e_busy = 0;
                        end else begin
                            m_t = 0; e_sig = 1; e_trig = 1;
                        end
                    end else begin
                        m_t = m_t + 1;
                        e_sig = (m_t < m_hi);
                    end
                end
            end
        endcase
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: advance the model on the edge, then compare all outputs.
    task automatic tick();
        @(posedge CLK);
        model_step();
        #1;
        chk("m_sig",  {31'd0, SIG_OUT}, {31'd0, e_sig});
        chk("m_trig", {31'd0, TRIG},    {31'd0, e_trig});
        chk("m_busy", {31'd0, BUSY},    {31'd0, e_busy});
        chk("m_done", {31'd0, DONE},    {31'd0, e_done});
        chk("m_pcnt", {24'd0, PULSE_CNT}, {24'd0, m_pc});
    endtask

    task automatic setp(input int per, input int hi, input int nb);
        PERIOD = 16'(per); HIGH_T = 16'(hi); NBURST = 8'(nb);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       start;
        int         per, hi, nb;
        logic       sig, trig, busy, done;
        logic [7:0] pc;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input int per, input int hi, input int nb,
                                input logic s, input logic t, input logic b, input logic d,
                                input int pc);
        vec_t v;
        v.start = st; v.per = per; v.hi = hi; v.nb = nb;
        v.sig = s; v.trig = t; v.busy = b; v.done = d; v.pc = 8'(pc);
        return v;
    endfunction

    int n_done;

    initial begin
        RSET = 1'b0; EN = 1'b0; START = 1'b0; STOP = 1'b0;
        setp(0, 0, 0);
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_sig",  {31'd0, SIG_OUT}, 32'd0);
        chk("rst_trig", {31'd0, TRIG},    32'd0);
        chk("rst_busy", {31'd0, BUSY},    32'd0);
        chk("rst_done", {31'd0, DONE},    32'd0);
        chk("rst_pcnt", {24'd0, PULSE_CNT}, 32'd0);
        @(negedge CLK);
        RSET = 1'b1; EN = 1'b1;

        // Clamp PERIOD=1/HIGH_T=0 -> 1 high / 1 low, two periods.
        tbl.push_back(mk(1, 1, 0, 2, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 2, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 2, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 2, 1, 1, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 2, 0, 0, 1, 0, 1));
        tbl.push_back(mk(0, 1, 0, 2, 0, 0, 0, 1, 2));
        tbl.push_back(mk(0, 1, 0, 2, 0, 0, 0, 0, 2));
        // Clamp PERIOD=5/HIGH_T=9 -> 4 high / 1 low, one period.
        tbl.push_back(mk(1, 5, 9, 1, 0, 0, 0, 0, 2));
        tbl.push_back(mk(0, 5, 9, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5, 9, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 5, 9, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5, 9, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5, 9, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5, 9, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 5, 9, 1, 0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 5, 9, 1, 0, 0, 0, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            START = tbl[i].start;
            setp(tbl[i].per, tbl[i].hi, tbl[i].nb);
            tick();
            chk("tbl_sig",  {31'd0, SIG_OUT}, {31'd0, tbl[i].sig});
            chk("tbl_trig", {31'd0, TRIG},    {31'd0, tbl[i].trig});
            chk("tbl_busy", {31'd0, BUSY},    {31'd0, tbl[i].busy});
            chk("tbl_done", {31'd0, DONE},    {31'd0, tbl[i].done});
            chk("tbl_pcnt", {24'd0, PULSE_CNT}, {24'd0, tbl[i].pc});
        end
        START = 1'b0;

        // Burst 10/4/3: rises after k+2, k+12, k+22; DONE after k+32.
        setp(10, 4, 3);
        START = 1'b1; tick(); START = 1'b0;
        for (int c = 1; c <= 34; c++) begin
            tick();
            chk("burst_trig", {31'd0, TRIG}, {31'd0, (c == 2 || c == 12 || c == 22)});
            chk("burst_sig", {31'd0, SIG_OUT}, {31'd0, (c >= 2 && c < 32 && ((c - 2) % 10) < 4)});
            if (c == 32) begin
                chk("burst_done", {31'd0, DONE}, 32'd1);
                chk("burst_pcnt", {24'd0, PULSE_CNT}, 32'd3);
                chk("burst_busy", {31'd0, BUSY}, 32'd0);
            end
        end

        // Graceful stop in the 2nd cycle of period 3 (continuous 8/4).
        setp(8, 4, 0);
        START = 1'b1; tick(); START = 1'b0;
        n_done = 0;
        for (int c = 1; c <= 32; c++) begin
            STOP = (c == 20);
            tick();
            n_done += int'(DONE);
            if (c == 18) chk("stop_trig3", {31'd0, TRIG}, 32'd1);
            if (c > 18)  chk("stop_notrig", {31'd0, TRIG}, 32'd0);
            if (c == 26) begin
                chk("stop_done", {31'd0, DONE}, 32'd1);
                chk("stop_pcnt", {24'd0, PULSE_CNT}, 32'd3);
            end
        end
        STOP = 1'b0;
        chk("stop_ndone", n_done, 32'd1);

        // Abort: EN drops in LOW of period 2.
        setp(10, 4, 0);
        START = 1'b1; tick(); START = 1'b0;
        n_done = 0;
        for (int c = 1; c <= 22; c++) begin
            EN = (c < 18);
            tick();
            n_done += int'(DONE);
            if (c == 18) begin
                chk("abort_busy", {31'd0, BUSY}, 32'd0);
                chk("abort_sig",  {31'd0, SIG_OUT}, 32'd0);
                chk("abort_pcnt", {24'd0, PULSE_CNT}, 32'd1);
            end
        end
        chk("abort_ndone", n_done, 32'd0);
        START = 1'b1; tick(); START = 1'b0;
        repeat (3) tick();
        chk("en0_start_busy", {31'd0, BUSY}, 32'd0);
        EN = 1'b1;

        // Parameter and START isolation while busy.
        setp(10, 4, 2);
        START = 1'b1; tick(); START = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (c == 5) PERIOD = 16'd20;
            START = (c == 14);
            tick();
            if (c == 12) chk("iso_trig", {31'd0, TRIG}, 32'd1);
            if (c == 15) chk("iso_pcnt", {24'd0, PULSE_CNT}, 32'd1);
            if (c == 22) begin
                chk("iso_done", {31'd0, DONE}, 32'd1);
                chk("iso_pcnt2", {24'd0, PULSE_CNT}, 32'd2);
            end
        end
        START = 1'b0;

        // Continuous wrap with PERIOD=2.
        setp(2, 1, 0);
        START = 1'b1; tick(); START = 1'b0;
        n_done = 0;
        for (int c = 1; c <= 520; c++) begin
            tick();
            n_done += int'(DONE);
            if (c == 512) chk("wrap_pcnt255", {24'd0, PULSE_CNT}, 32'd255);
            if (c == 514) begin
                chk("wrap_pcnt0", {24'd0, PULSE_CNT}, 32'd0);
                chk("wrap_busy", {31'd0, BUSY}, 32'd1);
            end
        end
        chk("wrap_ndone", n_done, 32'd0);
        EN = 1'b0; tick(); EN = 1'b1; tick();

        // Asynchronous reset in HIGH.
        setp(10, 4, 0);
        START = 1'b1; tick(); START = 1'b0;
        tick(); tick();
        chk("pre_rst_sig", {31'd0, SIG_OUT}, 32'd1);
        #1 RSET = 1'b0;
        model_reset();
        #1;
        chk("arst_sig",  {31'd0, SIG_OUT}, 32'd0);
        chk("arst_busy", {31'd0, BUSY},    32'd0);
        chk("arst_trig", {31'd0, TRIG},    32'd0);
        #1 RSET = 1'b1;
        repeat (4) tick();
        chk("post_rst_busy", {31'd0, BUSY}, 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            EN     = ($urandom_range(0, 99) != 0);
            START  = ($urandom_range(0, 7) == 0);
            STOP   = ($urandom_range(0, 39) == 0);
            PERIOD = 16'($urandom_range(0, 9));
            HIGH_T = 16'($urandom_range(0, 10));
            NBURST = 8'($urandom_range(0, 3));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gpio_sync_gen.md
Name: gpio_sync_gen

Overview:
- Transmit side of the GPIO sync link: generates the external square sync signal that a remote sync FSM locks onto on each rising edge.
- Programmable period and high time; runs as a finite burst or continuously.
- Emits a one-cycle TRIG aligned to every rising edge, which drives local chirp start.
- Sits between the control registers and the GPIO output pad, in the same clock domain as the chirp counters.

Parameters:
- CNT_W, 16, width of the period and high-time counters.
- BURST_W, 8, width of the burst-length input and the pulse counter.

Ports:
- CLK  in  1  system clock, rising-edge.
- RSET  in  1  asynchronous active-low reset.
- EN  in  1  level enable; deassertion aborts.
- START  in  1  start request, sampled in IDLE only.
- STOP  in  1  graceful stop request.
- PERIOD  in  CNT_W  sync period in CLK cycles.
- HIGH_T  in  CNT_W  high time in CLK cycles.
- NBURST  in  BURST_W  number of periods; 0 means continuous.
- SIG_OUT  out  1  square sync signal to the GPIO pad.
- TRIG  out  1  one-cycle pulse coincident with each SIG_OUT rising edge.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse on burst completion or graceful stop.
- PULSE_CNT  out  BURST_W  number of completed periods since the last START.

Behaviour:
- Interface:
  - One clock, CLK.
  - Reset RSET is asynchronous and active-low.
  - RSET=0 forces state IDLE and clears all outputs, the stop request and the latched parameters. This applies immediately, including mid-period.
- Reset values: SIG_OUT=0, TRIG=0, BUSY=0, DONE=0, PULSE_CNT=0.
- All outputs are registered.
- States:
  - IDLE: SIG_OUT=0. START=1 and EN=1 at a clock edge -> LOAD.
  - LOAD (one cycle):
    - Latch per=PERIOD, hi=HIGH_T, nb=NBURST.
    - Clamp: per<2 -> per=2; hi=0 -> hi=1; hi>=per -> hi=per-1.
    - Clear PULSE_CNT and stop_req.
    - -> HIGH.
  - HIGH: SIG_OUT=1 for exactly hi cycles, then -> LOW.
  - LOW: SIG_OUT=0 for exactly per-hi cycles. At the last LOW cycle, PULSE_CNT increments, then:
    - nb!=0 and PULSE_CNT+1==nb -> IDLE, DONE=1 for one cycle.
    - stop_req=1 -> IDLE, DONE=1 for one cycle.
    - otherwise -> HIGH, starting a new period.
- Timing:
  - START sampled at edge k.
  - SIG_OUT=1 and TRIG=1 become visible after edge k+2 (LOAD occupies one cycle).
  - TRIG is high only in the first cycle of each HIGH phase.
- Period is exact: the rising-to-rising edge distance of SIG_OUT equals per cycles for every period of a run.
- PERIOD, HIGH_T and NBURST changes while BUSY have no effect until the next START.
- START while BUSY is ignored.
- STOP:
  - STOP=1 in HIGH, LOW or LOAD sets sticky stop_req; the current period always completes in full.
  - STOP in IDLE is ignored.
  - If START and STOP are both high in IDLE, START is taken and STOP is ignored.
- EN deassert while BUSY: abort.
  - Next state is IDLE, SIG_OUT=0 after that edge, no DONE.
  - PULSE_CNT holds its value.
- Continuous mode (nb=0): PULSE_CNT wraps from 2^BURST_W-1 to 0 and generation continues.
- DONE and TRIG never assert in the same cycle.
- BUSY falls on the same edge on which DONE rises.
- Implementation: one CNT_W phase counter is reloaded at each phase entry and counts down. No combinational path from any input to any output.

Test Plan:
- Reset mid-run: RSET low during HIGH -> SIG_OUT, BUSY and TRIG go to 0 asynchronously. After release, the block stays IDLE until the next START.
- Burst: PERIOD=10, HIGH_T=4, NBURST=3, START pulse at edge k:
  - Rises after edges k+2, k+12 and k+22, each high 4 cycles.
  - TRIG pulses at those three points.
  - DONE after edge k+32, with PULSE_CNT=3 and BUSY=0.
- Clamping:
  - PERIOD=1, HIGH_T=0 -> 2-cycle period, 1 high / 1 low.
  - PERIOD=5, HIGH_T=9 -> 4 high / 1 low.
- Graceful stop: NBURST=0, PERIOD=8, HIGH_T=4, STOP asserted in the 2nd cycle of period 3 -> period 3 completes, then DONE with PULSE_CNT=3. No further TRIG.
- Abort: EN dropped in LOW of period 2 -> IDLE next edge, no DONE, PULSE_CNT=1. A START with EN=0 is ignored.
- Parameter and START isolation:
  - PERIOD changes from 10 to 20 while BUSY -> the period stays 10 until the next run.
  - A START pulse while BUSY causes no reload and no PULSE_CNT clear.
- Continuous-mode wrap: BURST_W=8, NBURST=0, PERIOD=2 -> after 256 periods PULSE_CNT wraps to 0, BUSY stays 1, and DONE never pulses.
